// File: rtl/rnn_param_loader_pkg.sv
// Shared types and widths for the RNN parameter loader: FSM state encoding
// and the select/data widths of the parameter storage write port.
package rnn_param_pkg;

  localparam int PARAM_W    = 16;
  localparam int ROW_SEL_W  = 2;
  localparam int COL_SEL_W  = 4;
  localparam int BIAS_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    FLUSH  = 2'd3
  } param_ld_state_t;

endpackage

// File: rtl/rnn_param_loader_if.sv
// Valid/ready parameter word stream from the host/DMA side into the loader.
interface rnn_param_loader_if;
  import rnn_param_pkg::*;

  logic               valid;
  logic               ready;
  logic [PARAM_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/rnn_param_loader.sv
// Streams ROWS*COLS weights (row-major) then BIAS_LEN biases into the cell's
// parameter storage through a registered write port; pulses o_done when complete.
module rnn_param_loader
  import rnn_param_pkg::*;
#(
  parameter int ROWS     = 2,
  parameter int COLS     = 4,
  parameter int BIAS_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  rnn_param_loader_if.slave     i_stream,
  output logic                  o_w_write,
  output logic [ROW_SEL_W-1:0]  o_w_seli,
  output logic [COL_SEL_W-1:0]  o_w_selj,
  output logic                  o_b_write,
  output logic [BIAS_SEL_W-1:0] o_b_sel,
  output logic [PARAM_W-1:0]    o_param_in,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LOAD_W = LOAD_W;
  localparam logic [1:0] S_LOAD_B = LOAD_B;
  localparam logic [1:0] S_FLUSH  = FLUSH;

  localparam logic [ROW_SEL_W-1:0]  ROW_LAST  = ROW_SEL_W'(ROWS - 1);
  localparam logic [COL_SEL_W-1:0]  COL_LAST  = COL_SEL_W'(COLS - 1);
  localparam logic [BIAS_SEL_W-1:0] BIAS_LAST = BIAS_SEL_W'(BIAS_LEN - 1);

  if (ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 16 ||
      BIAS_LEN < 1 || BIAS_LEN > 16) begin : g_bad_params
    $error("rnn_param_loader: ROWS must be 1..4, COLS and BIAS_LEN 1..16");
  end

  logic [1:0]            r_state;
  logic [ROW_SEL_W-1:0]  r_row;
  logic [COL_SEL_W-1:0]  r_col;
  logic [BIAS_SEL_W-1:0] r_bidx;
  logic                  r_w_write;
  logic [ROW_SEL_W-1:0]  r_w_seli;
  logic [COL_SEL_W-1:0]  r_w_selj;
  logic                  r_b_write;
  logic [BIAS_SEL_W-1:0] r_b_sel;
  logic [PARAM_W-1:0]    r_param;
  logic                  r_done;

  logic w_in_load;
  logic w_ready;
  logic w_accept;

  // abort gates ready combinationally so no beat is taken in the abort cycle
  assign w_in_load      = (r_state == S_LOAD_W) || (r_state == S_LOAD_B);
  assign w_ready        = w_in_load && !i_abort;
  assign w_accept       = i_stream.valid && w_ready;
  assign i_stream.ready = w_ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_bidx    <= '0;
      r_w_write <= 1'b0;
      r_w_seli  <= '0;
      r_w_selj  <= '0;
      r_b_write <= 1'b0;
      r_b_sel   <= '0;
      r_param   <= '0;
      r_done    <= 1'b0;
    end else begin
      // Strobes and done are single-cycle unless re-armed below.
      r_w_write <= 1'b0;
      r_b_write <= 1'b0;
      r_done    <= 1'b0;

      if (i_abort) begin
        r_state <= S_IDLE;
        r_row   <= '0;
        r_col   <= '0;
        r_bidx  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state <= S_LOAD_W;
              r_row   <= '0;
              r_col   <= '0;
              r_bidx  <= '0;
            end
          end

          S_LOAD_W: begin
            if (w_accept) begin
              r_w_write <= 1'b1;
              r_w_seli  <= r_row;
              r_w_selj  <= r_col;
              r_param   <= i_stream.data;
              if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row == ROW_LAST) begin
                  r_row   <= '0;
                  r_state <= S_LOAD_B;
                end else begin
                  r_row <= r_row + 2'd1;
                end
              end else begin
                r_col <= r_col + 4'd1;
              end
            end
          end

          S_LOAD_B: begin
            if (w_accept) begin
              r_b_write <= 1'b1;
              r_b_sel   <= r_bidx;
              r_param   <= i_stream.data;
              if (r_bidx == BIAS_LAST) begin
                r_bidx  <= '0;
                r_state <= S_FLUSH;
              end else begin
                r_bidx <= r_bidx + 4'd1;
              end
            end
          end

          S_FLUSH: begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_w_write  = r_w_write;
  assign o_w_seli   = r_w_seli;
  assign o_w_selj   = r_w_selj;
  assign o_b_write  = r_b_write;
  assign o_b_sel    = r_b_sel;
  assign o_param_in = r_param;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;

endmodule

// File: tb/tb_rnn_param_loader.sv
// Directed bench for rnn_param_loader: default instance with a storage model,
// plus a ROWS=1/COLS=16/BIAS_LEN=1 instance for the wide-column case.
module tb_rnn_param_loader;

  localparam int NTOT = 12;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic        w_write, b_write, busy, done;
  logic [1:0]  w_seli;
  logic [3:0]  w_selj, b_sel;
  logic [15:0] param_in;

  logic        p_start, p_abort;
  logic        p_w_write, p_b_write, p_busy, p_done;
  logic [1:0]  p_w_seli;
  logic [3:0]  p_w_selj, p_b_sel;
  logic [15:0] p_param_in;

  int n_pass  = 0;
  int n_total = 0;

  rnn_param_loader_if u_if ();
  rnn_param_loader_if p_if ();

  always #5 clk = ~clk;

  rnn_param_loader u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_stream(u_if),
    .o_w_write(w_write), .o_w_seli(w_seli), .o_w_selj(w_selj),
    .o_b_write(b_write), .o_b_sel(b_sel), .o_param_in(param_in),
    .o_busy(busy), .o_done(done)
  );

  rnn_param_loader #(.ROWS(1), .COLS(16), .BIAS_LEN(1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .i_start(p_start), .i_abort(p_abort), .i_stream(p_if),
    .o_w_write(p_w_write), .o_w_seli(p_w_seli), .o_w_selj(p_w_selj),
    .o_b_write(p_b_write), .o_b_sel(p_b_sel), .o_param_in(p_param_in),
    .o_busy(p_busy), .o_done(p_done)
  );

  // Parameter storage as the cell would hold it, cleared by the same reset.
  logic [15:0] wmem [4][16];
  logic [15:0] bmem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 16; j++) wmem[i][j] <= '0;
      for (int i = 0; i < 16; i++) bmem[i] <= '0;
    end else begin
      if (w_write) wmem[w_seli][w_selj] <= param_in;
      if (b_write) bmem[b_sel] <= param_in;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observations collected by run_stream for the test tasks to judge.
  int   rs_beats, rs_strobe_bad, rs_ready_bad, rs_done_delay;
  logic rs_timeout, rs_busy1, rs_ready_abort, rs_w_abort, rs_busy_abort;

  task automatic run_stream(input logic [15:0] base, input bit gaps,
                            input int start_at, input int abort_at, input int stop_at);
    bit prev_acc, sflag, fin;
    int last_k;
    rs_beats = 0; rs_strobe_bad = 0; rs_ready_bad = 0; rs_done_delay = -1;
    rs_timeout = 1'b0; prev_acc = 0; sflag = 0; fin = 0; last_k = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; rs_busy1 = busy;
    for (int k = 0; k < 200 && !fin; k++) begin
      if ((w_write | b_write) !== prev_acc || (w_write & b_write)) rs_strobe_bad++;
      if (done === 1'b1) begin
        rs_done_delay = k - last_k;
        fin = 1;
      end else if (rs_beats == stop_at) begin
        fin = 1;
      end else if (rs_beats == abort_at) begin
        abort = 1'b1; u_if.valid = 1'b1;
        #1;
        rs_ready_abort = u_if.ready;
        rs_w_abort     = w_write;
        @(negedge clk);
        abort = 1'b0; u_if.valid = 1'b0;
        rs_busy_abort = busy;
        fin = 1;
      end else begin
        u_if.valid = (rs_beats < NTOT) && (!gaps || (k % 2 == 0));
        u_if.data  = base + 16'(rs_beats);
        start      = (rs_beats == start_at) && !sflag;
        if (start) sflag = 1;
        #1;
        if (rs_beats < NTOT && u_if.ready !== 1'b1) rs_ready_bad++;
        prev_acc = u_if.valid && u_if.ready;
        if (prev_acc) begin
          rs_beats++;
          last_k = k;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!fin) rs_timeout = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    n_total++;
    if ({u_if.ready, w_write, b_write, busy, done} !== 5'b0)
      $display("FAIL reset_ctrl: ready/w/b/busy/done=%b want 00000",
               {u_if.ready, w_write, b_write, busy, done});
    else n_pass++;
    n_total++;
    if ({w_seli, w_selj, b_sel, param_in} !== 26'h0)
      $display("FAIL reset_sel: seli=%0d selj=%0d bsel=%0d param=%h want all 0",
               w_seli, w_selj, b_sel, param_in);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({busy, u_if.ready, done} !== 3'b000)
      $display("FAIL reset_idle: busy/ready/done=%b want 000", {busy, u_if.ready, done});
    else n_pass++;
  endtask

  task automatic test_full_load;
    run_stream(16'h0001, 0, -1, -1, -1);
    n_total++;
    if (rs_timeout !== 1'b0 || rs_done_delay !== 2)
      $display("FAIL full_done_delay: got %0d (timeout=%b) want 2", rs_done_delay, rs_timeout);
    else n_pass++;
    n_total++;
    if (rs_busy1 !== 1'b1) $display("FAIL full_busy_after_start: got %b want 1", rs_busy1);
    else n_pass++;
    n_total++;
    if (rs_strobe_bad !== 0 || rs_beats !== NTOT)
      $display("FAIL full_strobes: bad=%0d beats=%0d want 0 and 12", rs_strobe_bad, rs_beats);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, busy} !== 2'b00) $display("FAIL full_done_width: done/busy=%b want 00", {done, busy});
    else n_pass++;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) begin
        n_total++;
        if (wmem[i][j] !== 16'(1 + i*4 + j))
          $display("FAIL full_w[%0d][%0d]: got %h want %h", i, j, wmem[i][j], 16'(1 + i*4 + j));
        else n_pass++;
      end
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (bmem[i] !== 16'(9 + i)) $display("FAIL full_b[%0d]: got %h want %h", i, bmem[i], 16'(9 + i));
      else n_pass++;
    end
  endtask

  task automatic test_gaps;
    run_stream(16'h8000, 1, -1, -1, -1);
    n_total++;
    if (rs_strobe_bad !== 0 || rs_timeout !== 1'b0)
      $display("FAIL gaps_strobes: bad=%0d timeout=%b want 0", rs_strobe_bad, rs_timeout);
    else n_pass++;
    n_total++;
    if (rs_ready_bad !== 0) $display("FAIL gaps_ready: low cycles in load=%0d want 0", rs_ready_bad);
    else n_pass++;
    n_total++;
    if (rs_done_delay !== 2) $display("FAIL gaps_done_delay: got %0d want 2", rs_done_delay);
    else n_pass++;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) begin
        n_total++;
        if (wmem[i][j] !== 16'h8000 + 16'(i*4 + j))
          $display("FAIL gaps_w[%0d][%0d]: got %h want %h", i, j, wmem[i][j], 16'h8000 + 16'(i*4 + j));
        else n_pass++;
      end
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (bmem[i] !== 16'h8008 + 16'(i))
        $display("FAIL gaps_b[%0d]: got %h want %h", i, bmem[i], 16'h8008 + 16'(i));
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int late;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_stream(16'h0100, 0, -1, 5, -1);
    n_total++;
    if ({rs_ready_abort, rs_w_abort, rs_busy_abort} !== 3'b010)
      $display("FAIL abort_cycle: ready/w_write/busy_next=%b want 010",
               {rs_ready_abort, rs_w_abort, rs_busy_abort});
    else n_pass++;
    late = 0;
    for (int k = 0; k < 5; k++) begin
      if (done || w_write || b_write || busy) late++;
      @(negedge clk);
    end
    n_total++;
    if (late !== 0) $display("FAIL abort_quiet: active cycles=%0d want 0", late);
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (wmem[n/4][n%4] !== ((n < 5) ? 16'h0100 + 16'(n) : 16'h0000))
        $display("FAIL abort_w[%0d][%0d]: got %h want %h", n/4, n%4, wmem[n/4][n%4],
                 (n < 5) ? 16'h0100 + 16'(n) : 16'h0000);
      else n_pass++;
    end
    n_total++;
    if ({bmem[0], bmem[1], bmem[2], bmem[3]} !== 64'h0)
      $display("FAIL abort_bias: got %h %h %h %h want 0", bmem[0], bmem[1], bmem[2], bmem[3]);
    else n_pass++;
    run_stream(16'h0200, 0, -1, -1, -1);
    n_total++;
    if (rs_done_delay !== 2) $display("FAIL reload_done_delay: got %0d want 2", rs_done_delay);
    else n_pass++;
    for (int n = 0; n < 12; n++) begin
      n_total++;
      if (((n < 8) ? wmem[n/4][n%4] : bmem[n-8]) !== 16'h0200 + 16'(n))
        $display("FAIL reload_word%0d: got %h want %h", n,
                 (n < 8) ? wmem[n/4][n%4] : bmem[n-8], 16'h0200 + 16'(n));
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_start_busy_and_done;
    run_stream(16'h0300, 0, 3, -1, -1);
    n_total++;
    if (rs_beats !== NTOT || rs_done_delay !== 2)
      $display("FAIL start_busy_ignored: beats=%0d done_delay=%0d want 12 and 2",
               rs_beats, rs_done_delay);
    else n_pass++;
    n_total++;
    if (bmem[3] !== 16'h030B) $display("FAIL start_busy_last: got %h want 030b", bmem[3]);
    else n_pass++;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_total++;
    if ({busy, done} !== 2'b10) $display("FAIL start_in_done: busy/done=%b want 10", {busy, done});
    else n_pass++;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL start_in_done_abort: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load;
    int nz;
    run_stream(16'h0400, 0, -1, -1, 7);
    n_total++;
    if (rs_beats !== 7 || busy !== 1'b1)
      $display("FAIL rst_mid_setup: beats=%0d busy=%b want 7 and 1", rs_beats, busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({u_if.ready, w_write, b_write, busy, done, w_seli, w_selj, b_sel, param_in} !== 31'h0)
      $display("FAIL rst_mid_outputs: ready=%b w=%b b=%b busy=%b done=%b seli=%0d selj=%0d bsel=%0d param=%h want all 0",
               u_if.ready, w_write, b_write, busy, done, w_seli, w_selj, b_sel, param_in);
    else n_pass++;
    nz = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) if (wmem[i][j] !== 16'h0) nz++;
    for (int i = 0; i < 4; i++) if (bmem[i] !== 16'h0) nz++;
    n_total++;
    if (nz !== 0) $display("FAIL rst_mid_storage: nonzero entries=%0d want 0", nz);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; u_if.valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, u_if.ready} !== 2'b00)
      $display("FAIL rst_mid_idle: busy/ready=%b want 00", {busy, u_if.ready});
    else n_pass++;
  endtask

  task automatic test_params;
    int beats, last_k, delay;
    bit prev_acc;
    beats = 0; last_k = 0; delay = -1; prev_acc = 0;
    @(negedge clk); p_start = 1'b1;
    @(negedge clk); p_start = 1'b0;
    for (int k = 0; k < 60 && delay < 0; k++) begin
      if (prev_acc) begin
        n_total++;
        if (beats <= 16) begin
          if ({p_w_write, p_b_write, p_w_seli, p_w_selj, p_param_in} !==
              {1'b1, 1'b0, 2'd0, 4'(beats - 1), 16'h0A00 + 16'(beats - 1)})
            $display("FAIL param_w_beat%0d: w=%b b=%b seli=%0d selj=%0d data=%h want w=1 seli=0 selj=%0d data=%h",
                     beats, p_w_write, p_b_write, p_w_seli, p_w_selj, p_param_in,
                     beats - 1, 16'h0A00 + 16'(beats - 1));
          else n_pass++;
        end else begin
          if ({p_w_write, p_b_write, p_b_sel, p_param_in} !== {1'b0, 1'b1, 4'd0, 16'h0A10})
            $display("FAIL param_b_beat: w=%b b=%b bsel=%0d data=%h want b=1 bsel=0 data=0a10",
                     p_w_write, p_b_write, p_b_sel, p_param_in);
          else n_pass++;
        end
      end
      if (p_done === 1'b1) begin
        delay = k - last_k;
      end else begin
        p_if.valid = (beats < 17);
        p_if.data  = 16'h0A00 + 16'(beats);
        #1;
        prev_acc = p_if.valid && p_if.ready;
        if (prev_acc) begin
          beats++;
          last_k = k;
        end
        @(negedge clk);
      end
    end
    n_total++;
    if (beats !== 17 || delay !== 2)
      $display("FAIL param_done: beats=%0d done_delay=%0d want 17 and 2", beats, delay);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    u_if.valid = 1'b0; u_if.data = '0;
    p_start = 1'b0; p_abort = 1'b0;
    p_if.valid = 1'b0; p_if.data = '0;
    test_reset;
    test_full_load;
    test_gaps;
    test_abort;
    test_start_busy_and_done;
    test_reset_mid_load;
    test_params;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
